// File: rtl/run_ctrl.sv
// Start/Ack launch responder: holds the core in PC-init while Start is high, runs it until
// Halt or the watchdog fires, then raises Ack with the cycle count and final PC captured.
module run_ctrl #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic [PC_W-1:0]  prog_ctr_i,
    output logic             ack_o,
    output logic             pc_init_o,
    output logic             run_en_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [PC_W-1:0]  last_pc_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic              ack_q;
    logic              pc_init_q;
    logic              run_en_q;
    logic [CNT_W-1:0]  cycle_cnt_q;
    logic [PC_W-1:0]   last_pc_q;
    logic              timeout_q;

    logic [CNT_W-1:0]  cnt_inc_d;
    logic              go_arm_d;

    // The counter never exceeds TIMEOUT-1 while running, so the increment cannot wrap.
    assign cnt_inc_d = cycle_cnt_q + CNT_W'(1);
    // Start restarts from any state except ARM, where it simply keeps the core held.
    assign go_arm_d  = start_i && (state_q != ARM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            pc_init_q   <= 1'b0;
            run_en_q    <= 1'b0;
            cycle_cnt_q <= '0;
            last_pc_q   <= '0;
            timeout_q   <= 1'b0;
        end else if (go_arm_d) begin
            state_q     <= ARM;
            ack_q       <= 1'b0;
            pc_init_q   <= 1'b1;
            run_en_q    <= 1'b0;
            cycle_cnt_q <= '0;
            last_pc_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    if (!start_i) begin
                        state_q   <= RUN;
                        pc_init_q <= 1'b0;
                        run_en_q  <= 1'b1;
                    end
                end
                RUN: begin
                    // Halt takes priority over the watchdog on the same edge.
                    if (halt_i || (cnt_inc_d == TIMEOUT_C)) begin
                        state_q     <= DONE;
                        run_en_q    <= 1'b0;
                        ack_q       <= 1'b1;
                        cycle_cnt_q <= cnt_inc_d;
                        last_pc_q   <= prog_ctr_i;
                        timeout_q   <= ~halt_i;
                    end else begin
                        cycle_cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign pc_init_o   = pc_init_q;
    assign run_en_o    = run_en_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign last_pc_o   = last_pc_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized launch/run transactions for run_ctrl, checked against a per-transaction model
// that predicts the run outcome directly from the halt position and watchdog limit.
module tb_run_ctrl;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             halt = 1'b0;
    logic [PC_W-1:0]  prog_ctr = '0;
    logic             ack;
    logic             pc_init;
    logic             run_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic [PC_W-1:0]  last_pc;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    run_ctrl #(
        .PC_W    (PC_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .halt_i      (halt),
        .prog_ctr_i  (prog_ctr),
        .ack_o       (ack),
        .pc_init_o   (pc_init),
        .run_en_o    (run_en),
        .cycle_cnt_o (cycle_cnt),
        .last_pc_o   (last_pc),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ack"}, 32'(ack), 0);
        check_val({tag, "_pcinit"}, 32'(pc_init), 0);
        check_val({tag, "_runen"}, 32'(run_en), 0);
        check_val({tag, "_cnt"}, 32'(cycle_cnt), 0);
        check_val({tag, "_lastpc"}, 32'(last_pc), 0);
        check_val({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic check_armed(input string tag);
        check_val({tag, "_pcinit"}, 32'(pc_init), 1);
        check_val({tag, "_runen"}, 32'(run_en), 0);
        check_val({tag, "_ack"}, 32'(ack), 0);
        check_val({tag, "_cnt"}, 32'(cycle_cnt), 0);
        check_val({tag, "_lastpc"}, 32'(last_pc), 0);
        check_val({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    // One launch: Start high for start_len edges, then run until Halt on RUN edge halt_at
    // (0 = never), optionally restarting with Start+Halt on RUN edge restart_at.
    task automatic run_txn(input int start_len, input int halt_at, input int restart_at,
                           input int fixed_pc);
        int e;
        int end_e;
        int gap;
        bit restarted;
        bit finished;
        bit exp_to;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] end_pc;

        exp_to   = !(halt_at >= 1 && halt_at <= TO);
        end_e    = exp_to ? TO : halt_at;
        end_pc   = '0;
        e        = 0;
        restarted = 0;
        finished = 0;

        start = 1'b1;
        for (int i = 0; i < start_len; i++) begin
            halt = 1'($urandom_range(0, 1));
            tick();
            check_armed("arm");
        end
        start = 1'b0;
        halt  = 1'($urandom_range(0, 1));
        tick();
        check_val("enter_run_runen", 32'(run_en), 1);
        check_val("enter_run_pcinit", 32'(pc_init), 0);

        for (int guard = 0; guard < 64 && !finished; guard++) begin
            e++;
            pc = (fixed_pc >= 0) ? PC_W'(fixed_pc) : PC_W'($urandom);
            prog_ctr = pc;
            if (!restarted && e == restart_at) begin
                start = 1'b1;
                halt  = 1'b1;
                tick();
                check_armed("restart");
                start = 1'b0;
                halt  = 1'b0;
                tick();
                check_val("rerun_runen", 32'(run_en), 1);
                restarted = 1;
                e = 0;
            end else begin
                halt = (e == halt_at);
                tick();
                if (e == end_e) begin
                    end_pc = pc;
                    check_val("done_ack", 32'(ack), 1);
                    check_val("done_runen", 32'(run_en), 0);
                    check_val("done_pcinit", 32'(pc_init), 0);
                    check_val("done_cnt", 32'(cycle_cnt), 32'(end_e));
                    check_val("done_lastpc", 32'(last_pc), 32'(pc));
                    check_val("done_timeout", 32'(timeout), 32'(exp_to));
                    finished = 1;
                end else begin
                    check_val("run_cnt", 32'(cycle_cnt), 32'(e));
                    check_val("run_runen", 32'(run_en), 1);
                    check_val("run_ack", 32'(ack), 0);
                end
            end
        end
        if (!finished) check_val("txn_end", 0, 1);

        start = 1'b0;
        gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) begin
            halt     = 1'($urandom_range(0, 1));
            prog_ctr = PC_W'($urandom);
            tick();
            check_val("hold_ack", 32'(ack), 1);
            check_val("hold_cnt", 32'(cycle_cnt), 32'(end_e));
            check_val("hold_lastpc", 32'(last_pc), 32'(end_pc));
            check_val("hold_timeout", 32'(timeout), 32'(exp_to));
        end
        halt = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check_all_zero("idle");

        run_txn(1, 5, 0, 'h02A);
        run_txn(3, 2, 0, -1);
        run_txn(1, 0, 0, -1);
        run_txn(2, TO, 0, -1);
        run_txn(1, 6, 3, -1);

        // Asynchronous reset in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_val("prereset_cnt", 32'(cycle_cnt), 2);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        tick();
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        tick();
        check_all_zero("post_rst");

        for (int t = 0; t < 40; t++) begin
            run_txn($urandom_range(1, 3), $urandom_range(0, 12),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
